// File: rtl/pll_dyn_ctrl_if.sv
// Request/status bundle between a retune client (master) and pll_dyn_ctrl (slave).
interface pll_dyn_ctrl_if;
    logic       req;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       locked;
    logic       lock_lost;

    modport master (
        output req, cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda,
        input  busy, done, timeout, locked, lock_lost
    );

    modport slave (
        input  req, cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda,
        output busy, done, timeout, locked, lock_lost
    );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Gowin rPLL dynamic-configuration sequencer: reset, divider/phase codes, lock qualification.
// Optional build macro PLL_DYN_CTRL_RETRY_EN re-runs the PLL reset up to MAX_RETRY times.
module pll_dyn_ctrl #(
    parameter logic [5:0]  INIT_IDSEL   = 6'd60,
    parameter logic [5:0]  INIT_FBDSEL  = 6'd41,
    parameter logic [5:0]  INIT_ODSEL   = 6'd56,
    parameter logic [3:0]  INIT_PSDA    = 4'd0,
    parameter logic [3:0]  INIT_DUTYDA  = 4'd8,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 270000,
    parameter int unsigned PHASE_SETTLE = 4,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    pll_dyn_ctrl_if.slave ctrl,
    input  logic          pll_lock_i,
    output logic          pll_reset_o,
    output logic [5:0]    pll_idsel_o,
    output logic [5:0]    pll_fbdsel_o,
    output logic [5:0]    pll_odsel_o,
    output logic [3:0]    pll_psda_o,
    output logic [3:0]    pll_dutyda_o
);

    localparam int unsigned RstW    = $clog2(RST_CYCLES + 1);
    localparam int unsigned StableW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TmoW    = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SettleW = $clog2(PHASE_SETTLE + 1);

    localparam logic [RstW-1:0]    RstLast   = RstW'(RST_CYCLES - 1);
    localparam logic [StableW-1:0] StableMax = StableW'(LOCK_STABLE);
    localparam logic [TmoW-1:0]    TmoMax    = TmoW'(LOCK_TIMEOUT);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(PHASE_SETTLE);

    typedef enum logic [2:0] {
        StBoot, StRstHold, StWaitLock, StPhaseWait, StIdle, StError
    } state_e;

    state_e             state_q, state_d;
    logic               lock_meta_q, lock_s_q;
    logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [StableW-1:0] stable_q, stable_d, stable_nxt;
    logic [TmoW-1:0]    tmo_q, tmo_d, tmo_nxt;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [5:0]         idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic [3:0]         psda_q, psda_d, dutyda_q, dutyda_d;
    logic               pll_reset_q, pll_reset_d, busy_q, busy_d, done_q, done_d;
    logic               locked_q, locked_d, timeout_q, timeout_d, lost_q, lost_d;
    logic               accept, div_same;

`ifdef PLL_DYN_CTRL_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    logic [RetryW-1:0] retry_q, retry_d;
`else
    logic unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
`endif

    // A req landing on the done cycle is dropped so the caller sees a clean completion.
    assign accept   = ctrl.req && !done_q && (state_q == StIdle || state_q == StError);
    assign div_same = (ctrl.cfg_idsel == idsel_q) && (ctrl.cfg_fbdsel == fbdsel_q) &&
                      (ctrl.cfg_odsel == odsel_q);

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        stable_d   = stable_q;
        tmo_d      = tmo_q;
        settle_d   = settle_q;
        idsel_d    = idsel_q;
        fbdsel_d   = fbdsel_q;
        odsel_d    = odsel_q;
        psda_d     = psda_q;
        dutyda_d   = dutyda_q;
        done_d     = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        lost_d     = lost_q;
`ifdef PLL_DYN_CTRL_RETRY_EN
        retry_d    = retry_q;
`endif
        stable_nxt = !lock_s_q ? '0 :
                     (stable_q == StableMax) ? stable_q : stable_q + StableW'(1);
        tmo_nxt    = (tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1);

        unique case (state_q)
            StBoot: begin
                idsel_d   = INIT_IDSEL;
                fbdsel_d  = INIT_FBDSEL;
                odsel_d   = INIT_ODSEL;
                psda_d    = INIT_PSDA;
                dutyda_d  = INIT_DUTYDA;
                locked_d  = 1'b0;
                rst_cnt_d = '0;
`ifdef PLL_DYN_CTRL_RETRY_EN
                retry_d   = '0;
`endif
                state_d   = StRstHold;
            end
            StRstHold: begin
                if (rst_cnt_q == RstLast) begin
                    stable_d = '0;
                    tmo_d    = '0;
                    state_d  = StWaitLock;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstW'(1);
                end
            end
            StWaitLock: begin
                stable_d = stable_nxt;
                tmo_d    = tmo_nxt;
                if (stable_nxt == StableMax) begin
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else if (tmo_nxt == TmoMax) begin
`ifdef PLL_DYN_CTRL_RETRY_EN
                    if (retry_q == RetryMax) begin
                        timeout_d = 1'b1;
                        state_d   = StError;
                    end else begin
                        retry_d   = retry_q + RetryW'(1);
                        rst_cnt_d = '0;
                        state_d   = StRstHold;
                    end
`else
                    timeout_d = 1'b1;
                    state_d   = StError;
`endif
                end
            end
            StPhaseWait: begin
                if (settle_q == SettleMax) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            StIdle: begin
                if (locked_q && !lock_s_q) begin
                    locked_d = 1'b0;
                    lost_d   = 1'b1;
                end
            end
            StError: ;
            default: state_d = StBoot;
        endcase

        if (accept) begin
            timeout_d = 1'b0;
            lost_d    = 1'b0;
            psda_d    = ctrl.cfg_psda;
            dutyda_d  = ctrl.cfg_dutyda;
`ifdef PLL_DYN_CTRL_RETRY_EN
            retry_d   = '0;
`endif
            if (locked_q && lock_s_q && div_same) begin
                settle_d = '0;
                state_d  = StPhaseWait;
            end else begin
                idsel_d   = ctrl.cfg_idsel;
                fbdsel_d  = ctrl.cfg_fbdsel;
                odsel_d   = ctrl.cfg_odsel;
                locked_d  = 1'b0;
                rst_cnt_d = '0;
                state_d   = StRstHold;
            end
        end

        pll_reset_d = (state_d == StBoot) || (state_d == StRstHold);
        busy_d      = (state_d != StIdle) && (state_d != StError);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            settle_q    <= '0;
            idsel_q     <= INIT_IDSEL;
            fbdsel_q    <= INIT_FBDSEL;
            odsel_q     <= INIT_ODSEL;
            psda_q      <= INIT_PSDA;
            dutyda_q    <= INIT_DUTYDA;
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            lost_q      <= 1'b0;
`ifdef PLL_DYN_CTRL_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            settle_q    <= settle_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            psda_q      <= psda_d;
            dutyda_q    <= dutyda_d;
            pll_reset_q <= pll_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            lost_q      <= lost_d;
`ifdef PLL_DYN_CTRL_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.timeout   = timeout_q;
    assign ctrl.locked    = locked_q;
    assign ctrl.lock_lost = lost_q;
    assign pll_reset_o    = pll_reset_q;
    assign pll_idsel_o    = idsel_q;
    assign pll_fbdsel_o   = fbdsel_q;
    assign pll_odsel_o    = odsel_q;
    assign pll_psda_o     = psda_q;
    assign pll_dutyda_o   = dutyda_q;

endmodule
